// File: rtl/sme_feeder_if.sv
// rtl/sme_feeder_if.sv - character bus between the feeder and the string-matching engine
// Signals:
//   chardata    8  character toward the engine (0 when no strobe is high)
//   isstring    1  string character strobe
//   ispattern   1  pattern character strobe
//   valid       1  engine result strobe
//   match       1  engine match flag, qualified by valid
//   match_index 5  engine match position, qualified by valid
// Modports: master = feeder side, slave = engine side.
`timescale 1ns/1ps
interface sme_feeder_if;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    modport master (
        output chardata,
        output isstring,
        output ispattern,
        input  valid,
        input  match,
        input  match_index
    );

    modport slave (
        input  chardata,
        input  isstring,
        input  ispattern,
        output valid,
        output match,
        output match_index
    );
endinterface

// File: rtl/sme_feeder.sv
// rtl/sme_feeder.sv - buffers one string and up to NPAT patterns and plays them onto the matching engine
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   ld_en/ld_sel/ld_data/ld_last  byte load port (IDLE only); ld_sel 0 = string, 1 = pattern
//   start             begin playback (IDLE only, ignored together with ld_en)
//   busy              high in every state except IDLE
//   res_*             one-cycle result per pattern (match, index, slot, timeout flag)
//   done              pulses with the last result of a run
//   eng               engine character bus (master side)
`timescale 1ns/1ps
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int NPAT    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_en,
    input  logic       ld_sel,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    input  logic       start,
    output logic       busy,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_pat,
    output logic       res_timeout,
    output logic       done,
    sme_feeder_if.master eng
);
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int KW  = $clog2(STR_MAX);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int JW  = $clog2(PAT_MAX);
    localparam int PCW = $clog2(NPAT + 1);
    localparam int PW  = $clog2(NPAT);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_STR, S_PAT, S_WAIT} state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [JW-1:0]   j, j_n;
    logic [PW-1:0]   p, p_n;
    logic [TW-1:0]   wcnt, wcnt_n;

    logic [SW-1:0]   str_len;
    logic [PCW-1:0]  pat_cnt;
    logic [PLW-1:0]  plen [NPAT];
    logic            str_closed;
    logic [7:0]      str_mem [STR_MAX];
    logic [7:0]      pat_mem [NPAT][PAT_MAX];

    logic [7:0]      cd_n;
    logic            is_n, ip_n, rv_n, rm_n, rt_n, done_n;
    logic [4:0]      ri_n;
    logic [1:0]      rp_n;

    // Load-port decode; loads are accepted only while idle.
    logic            load;
    logic            str_we;
    logic [KW-1:0]   str_wa;
    logic [PW-1:0]   pslot;
    logic            pat_room;
    logic            pat_we;
    logic [JW-1:0]   pat_wa;

    assign load     = ld_en && (state == S_IDLE);
    assign str_we   = load && !ld_sel && (str_closed || (str_len < SW'(STR_MAX)));
    // A byte arriving after the string was closed starts a fresh string at 0.
    assign str_wa   = str_closed ? '0 : str_len[KW-1:0];
    assign pslot    = pat_cnt[PW-1:0];
    assign pat_room = pat_cnt < PCW'(NPAT);
    assign pat_we   = load && ld_sel && pat_room && (plen[pslot] < PLW'(PAT_MAX));
    assign pat_wa   = plen[pslot][JW-1:0];

    logic last_str, last_pat_char, last_pat, timed_out;
    assign last_str      = (SW'(k) + SW'(1)) == str_len;
    assign last_pat_char = (PLW'(j) + PLW'(1)) == plen[p];
    assign last_pat      = (PCW'(p) + PCW'(1)) == pat_cnt;
    // Counter starts at 0 on WAIT entry, so TIMEOUT-1 marks the last waited cycle.
    assign timed_out     = wcnt == TW'(TIMEOUT - 1);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            if (str_we) str_mem[str_wa] <= ld_data;
            if (pat_we) pat_mem[pslot][pat_wa] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            str_len    <= '0;
            pat_cnt    <= '0;
            str_closed <= 1'b1;
            for (int i = 0; i < NPAT; i++) plen[i] <= '0;
        end else if (load) begin
            if (!ld_sel) begin
                if (str_closed) begin
                    // New string invalidates every pattern loaded for the old one.
                    str_len <= SW'(1);
                    pat_cnt <= '0;
                    for (int i = 0; i < NPAT; i++) plen[i] <= '0;
                end else if (str_len < SW'(STR_MAX)) begin
                    str_len <= str_len + 1'b1;
                end
                str_closed <= ld_last;
            end else if (pat_room) begin
                if (plen[pslot] < PLW'(PAT_MAX)) plen[pslot] <= plen[pslot] + 1'b1;
                if (ld_last) pat_cnt <= pat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            k               <= '0;
            j               <= '0;
            p               <= '0;
            wcnt            <= '0;
            eng.chardata    <= '0;
            eng.isstring    <= 1'b0;
            eng.ispattern   <= 1'b0;
            res_valid       <= 1'b0;
            res_match       <= 1'b0;
            res_index       <= '0;
            res_pat         <= '0;
            res_timeout     <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            k               <= k_n;
            j               <= j_n;
            p               <= p_n;
            wcnt            <= wcnt_n;
            eng.chardata    <= cd_n;
            eng.isstring    <= is_n;
            eng.ispattern   <= ip_n;
            res_valid       <= rv_n;
            res_match       <= rm_n;
            res_index       <= ri_n;
            res_pat         <= rp_n;
            res_timeout     <= rt_n;
            done            <= done_n;
        end
    end

    // The state register names what is on the bus in the current cycle, so every
    // transition also computes the character that the next cycle will carry.
    always_comb begin
        state_n = state;
        k_n     = k;
        j_n     = j;
        p_n     = p;
        wcnt_n  = wcnt;
        cd_n    = '0;
        is_n    = 1'b0;
        ip_n    = 1'b0;
        rv_n    = 1'b0;
        rm_n    = 1'b0;
        ri_n    = '0;
        rp_n    = '0;
        rt_n    = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !ld_en && (str_len != '0) && (pat_cnt != '0)) begin
                    state_n = S_STR;
                    k_n     = '0;
                    cd_n    = str_mem[0];
                    is_n    = 1'b1;
                end
            end
            S_STR: begin
                if (last_str) begin
                    state_n = S_PAT;
                    p_n     = '0;
                    j_n     = '0;
                    cd_n    = pat_mem[0][0];
                    ip_n    = 1'b1;
                end else begin
                    k_n  = k + 1'b1;
                    cd_n = str_mem[k_n];
                    is_n = 1'b1;
                end
            end
            S_PAT: begin
                if (last_pat_char) begin
                    state_n = S_WAIT;
                    wcnt_n  = '0;
                end else begin
                    j_n  = j + 1'b1;
                    cd_n = pat_mem[p][j_n];
                    ip_n = 1'b1;
                end
            end
            S_WAIT: begin
                wcnt_n = wcnt + 1'b1;
                if (eng.valid || timed_out) begin
                    rv_n = 1'b1;
                    rm_n = eng.valid && eng.match;
                    ri_n = eng.valid ? eng.match_index : 5'd0;
                    rp_n = 2'(p);
                    rt_n = !eng.valid;
                    if (last_pat) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        // Next pattern goes out in the same cycle as this result.
                        state_n = S_PAT;
                        p_n     = p + 1'b1;
                        j_n     = '0;
                        cd_n    = pat_mem[p_n][0];
                        ip_n    = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sme_feeder.sv
// tb/tb_sme_feeder.sv - self-checking bench for sme_feeder
`timescale 1ns/1ps
module tb_sme_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ld_en, ld_sel, ld_last, start;
    logic [7:0] ld_data;
    logic       busy, res_valid, res_match, res_timeout, done;
    logic [4:0] res_index;
    logic [1:0] res_pat;

    sme_feeder_if eng();

    sme_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .ld_en      (ld_en),
        .ld_sel     (ld_sel),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .start      (start),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_match  (res_match),
        .res_index  (res_index),
        .res_pat    (res_pat),
        .res_timeout(res_timeout),
        .done       (done),
        .eng        (eng)
    );

    typedef struct {
        bit          start;
        bit          ld;
        bit          v;
        bit          m;
        logic [4:0]  ix;
        logic [21:0] exp;
    } tv_t;

    int checks = 0;
    int errors = 0;

    // Reference buffer contents, updated by the load rules.
    logic [7:0] m_str[$];
    logic [7:0] m_pat[4][8];
    int         m_plen[4];
    int         m_pcnt;
    bit         m_closed;

    // Engine behaviour per pattern slot: jd = cycles after last char until valid (0 = never).
    int         jd[4];
    bit         jm[4];
    logic [4:0] jix[4];

    tv_t tr[$];
    tv_t tab[10];

    function automatic logic [21:0] mk(bit b, logic [7:0] cd, bit is, bit ip, bit rv, bit rm,
                                       logic [4:0] ri, logic [1:0] rp, bit rt, bit dn);
        return {b, cd, is, ip, rv, rm, ri, rp, rt, dn};
    endfunction

    function automatic logic [21:0] obs();
        return {busy, eng.chardata, eng.isstring, eng.ispattern, res_valid, res_match,
                res_index, res_pat, res_timeout, done};
    endfunction

    function automatic tv_t row(bit st, bit v, bit m, logic [4:0] ix, logic [21:0] exp);
        tv_t r;
        r = '{default: 0};
        r.start = st; r.v = v; r.m = m; r.ix = ix; r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_str.delete();
        m_pcnt   = 0;
        m_closed = 1'b1;
        foreach (m_plen[i]) m_plen[i] = 0;
    endfunction

    function automatic void model_load(bit sel, logic [7:0] d, bit last);
        if (!sel) begin
            if (m_closed) begin
                m_str.delete();
                m_pcnt = 0;
                foreach (m_plen[i]) m_plen[i] = 0;
            end
            if (m_str.size() < 32) m_str.push_back(d);
            m_closed = last;
        end else if (m_pcnt < 4) begin
            if (m_plen[m_pcnt] < 8) begin
                m_pat[m_pcnt][m_plen[m_pcnt]] = d;
                m_plen[m_pcnt]++;
            end
            if (last) m_pcnt++;
        end
    endfunction

    task automatic load_byte(input bit sel, input logic [7:0] d, input bit last);
        ld_en = 1'b1; ld_sel = sel; ld_data = d; ld_last = last;
        model_load(sel, d, last);
        step();
        ld_en = 1'b0; ld_last = 1'b0;
    endtask

    task automatic load_text(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) load_byte(sel, s[i], i == s.len() - 1);
    endtask

    task automatic idle_inputs();
        start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        eng.valid = 1'b0; eng.match = 1'b0; eng.match_index = 5'd0;
    endtask

    // Builds the expected cycle-by-cycle trace of one run from the buffered job and
    // the engine plan, then replays it against the DUT starting with start in cycle 0.
    task automatic run_job(input string name, input bit noise);
        tv_t         e;
        logic [21:0] pend;
        int          nw;
        tr.delete();
        pend = '0;
        e = '{default: 0};
        e.start = 1'b1;
        tr.push_back(e);
        foreach (m_str[k]) begin
            e = '{default: 0};
            e.exp = mk(1, m_str[k], 1, 0, 0, 0, 5'd0, 2'd0, 0, 0);
            e.ld  = noise && ($urandom_range(0, 3) == 0);
            e.v   = noise && ($urandom_range(0, 2) == 0);
            e.m   = 1'b1;
            e.ix  = 5'($urandom);
            tr.push_back(e);
        end
        for (int p = 0; p < m_pcnt; p++) begin
            for (int j = 0; j < m_plen[p]; j++) begin
                e = '{default: 0};
                e.exp = mk(1, m_pat[p][j], 0, 1, 0, 0, 5'd0, 2'd0, 0, 0) | ((j == 0) ? pend : 22'd0);
                e.ld  = noise && ($urandom_range(0, 3) == 0);
                e.v   = noise && ($urandom_range(0, 2) == 0);
                e.m   = 1'b1;
                e.ix  = 5'($urandom);
                tr.push_back(e);
            end
            nw = (jd[p] != 0) ? jd[p] : 255;
            for (int w = 0; w < nw; w++) begin
                e = '{default: 0};
                e.exp = mk(1, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0);
                e.ld  = noise && ($urandom_range(0, 3) == 0);
                e.m   = 1'($urandom);
                e.ix  = 5'($urandom);
                if (w == nw - 1 && jd[p] != 0) begin
                    e.v = 1'b1; e.m = jm[p]; e.ix = jix[p];
                end
                tr.push_back(e);
            end
            pend = mk(0, 8'h00, 0, 0, 1, (jd[p] != 0) && jm[p], (jd[p] != 0) ? jix[p] : 5'd0,
                      2'(p), jd[p] == 0, 0);
        end
        e = '{default: 0};
        e.exp = pend | mk(0, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 1);
        tr.push_back(e);
        e = '{default: 0};
        tr.push_back(e);
        foreach (tr[c]) begin
            start         = tr[c].start;
            ld_en         = tr[c].ld;
            ld_sel        = 1'($urandom);
            ld_data       = 8'($urandom);
            ld_last       = 1'($urandom);
            eng.valid     = tr[c].v;
            eng.match     = tr[c].m;
            eng.match_index = tr[c].ix;
            check($sformatf("%s c%0d", name, c), obs(), tr[c].exp);
            step();
        end
        idle_inputs();
    endtask

    task automatic load_rand_job();
        int n, np, pl;
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) load_byte(0, 8'($urandom), i == n - 1);
        np = $urandom_range(1, 5);
        for (int q = 0; q < np; q++) begin
            pl = $urandom_range(1, 10);
            for (int i = 0; i < pl; i++) load_byte(1, 8'($urandom), i == pl - 1);
        end
        for (int q = 0; q < 4; q++) begin
            jd[q]  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            jm[q]  = 1'($urandom);
            jix[q] = 5'($urandom);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        step();
        step();
        check("reset_outputs", obs(), 22'd0);
        reset = 1'b1;
        step();

        // "abc" / "b": engine answers in cycle 7, result and done in cycle 8.
        load_text(0, "abc");
        load_text(1, "b");
        tab[0] = row(1, 0, 0, 5'd0, mk(0, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[1] = row(0, 0, 0, 5'd0, mk(1, 8'h61, 1, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[2] = row(0, 0, 0, 5'd0, mk(1, 8'h62, 1, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[3] = row(0, 0, 0, 5'd0, mk(1, 8'h63, 1, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[4] = row(0, 0, 0, 5'd0, mk(1, 8'h62, 0, 1, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[5] = row(0, 0, 0, 5'd0, mk(1, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[6] = row(0, 0, 0, 5'd0, mk(1, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[7] = row(0, 1, 1, 5'd1, mk(1, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        tab[8] = row(0, 0, 0, 5'd0, mk(0, 8'h00, 0, 0, 1, 1, 5'd1, 2'd0, 0, 1));
        tab[9] = row(0, 0, 0, 5'd0, mk(0, 8'h00, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            start = tab[i].start;
            eng.valid = tab[i].v;
            eng.match = tab[i].m;
            eng.match_index = tab[i].ix;
            check($sformatf("table c%0d", i), obs(), tab[i].exp);
            step();
        end
        idle_inputs();

        // Three patterns, engine answers 3 cycles after each pattern ends.
        load_text(0, "abc");
        load_text(1, "a");
        load_text(1, "^b");
        load_text(1, "c$");
        jd = '{3, 3, 3, 3};
        jm = '{1'b1, 1'b0, 1'b1, 1'b0};
        jix = '{5'd0, 5'd0, 5'd2, 5'd0};
        run_job("three_pat", 0);

        // Truncation to 32/8 and a timeout followed by a normal pattern.
        for (int i = 0; i < 40; i++) load_byte(0, 8'($urandom), i == 39);
        for (int i = 0; i < 10; i++) load_byte(1, 8'($urandom), i == 9);
        load_text(1, "zz");
        jd[0] = 0;
        jd[1] = 2; jm[1] = 1'b1; jix[1] = 5'd7;
        run_job("long_timeout", 1);

        // Reset in the middle of pattern playback.
        load_text(0, "xy");
        load_text(1, "pqrs");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("before_reset", obs(), mk(1, 8'h70, 0, 1, 0, 0, 5'd0, 2'd0, 0, 0));
        reset = 1'b0;
        step();
        check("reset_abort", obs(), 22'd0);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; eng.valid = 1'b1; eng.match = 1'b1;
            step();
            check($sformatf("empty_start%0d", i), obs(), 22'd0);
        end
        idle_inputs();
        load_text(0, "xy");
        load_text(1, "pqrs");
        jd[0] = 4; jm[0] = 1'b0; jix[0] = 5'd3;
        run_job("after_reset", 0);

        // String only: start and stray valid must do nothing.
        load_text(0, "hello");
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; eng.valid = 1'b1; eng.match = 1'b1;
            step();
            check($sformatf("nopat%0d", i), obs(), 22'd0);
        end
        idle_inputs();
        start = 1'b1;
        load_byte(1, 8'h6c, 1);
        start = 1'b0;
        check("start_with_load", obs(), 22'd0);
        jd[0] = 5; jm[0] = 1'b1; jix[0] = 5'd2;
        run_job("replay0", 1);
        run_job("replay1", 1);

        for (int it = 0; it < 12; it++) begin
            load_rand_job();
            run_job($sformatf("rnd%0d", it), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
